// File: rtl/issue_ctrl_if.sv
// Bundle of the fetch, decoder and execution-resource signals seen by issue_ctrl.
// master = the issue controller, slave = fetch/decoder/execution side.
interface issue_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic             dec_req_o;
  logic             req_rf_ra_i;
  logic             req_rf_rb_i;
  logic             req_alu_i;
  logic             req_data_i;
  logic             we_data_i;
  logic             req_pc_alu_i;
  logic             rd_we_i;
  logic [4:0]       rf_waddr_i;
  logic             rf_req_o;
  logic             rf_ack_i;
  logic             alu_req_o;
  logic             alu_ack_i;
  logic             lsu_req_o;
  logic             lsu_ack_i;
  logic             lsu_we_o;
  logic             pc_req_o;
  logic             pc_ack_i;
  logic             pc_seq_o;
  logic             wb_req_o;
  logic             wb_ack_i;
  logic             retire_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    input  instr_valid_i, req_rf_ra_i, req_rf_rb_i, req_alu_i, req_data_i,
           we_data_i, req_pc_alu_i, rd_we_i, rf_waddr_i,
           rf_ack_i, alu_ack_i, lsu_ack_i, pc_ack_i, wb_ack_i,
    output instr_ready_o, dec_req_o, rf_req_o, alu_req_o, lsu_req_o, lsu_we_o,
           pc_req_o, pc_seq_o, wb_req_o, retire_o, retire_cnt_o, busy_o, err_o
  );

  modport slave (
    output instr_valid_i, req_rf_ra_i, req_rf_rb_i, req_alu_i, req_data_i,
           we_data_i, req_pc_alu_i, rd_we_i, rf_waddr_i,
           rf_ack_i, alu_ack_i, lsu_ack_i, pc_ack_i, wb_ack_i,
    input  instr_ready_o, dec_req_o, rf_req_o, alu_req_o, lsu_req_o, lsu_we_o,
           pc_req_o, pc_seq_o, wb_req_o, retire_o, retire_cnt_o, busy_o, err_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue sequencer: accepts one instruction, pulses the decoder, then
// walks RF -> EXEC -> MEM -> PC -> WB over req/ack handshakes and retires.
// All outputs are registered and derived from the next state (Moore).
module issue_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  issue_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_FLAGS, S_RF, S_EXEC, S_MEM, S_PC, S_WB, S_RETIRE, S_ERROR
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [15:0]      wait_cnt_reg;
  logic             rf_flag_reg, alu_flag_reg, mem_flag_reg, we_flag_reg;
  logic             pc_flag_reg, wb_flag_reg;
  logic             instr_ready_reg, dec_req_reg, rf_req_reg, alu_req_reg;
  logic             lsu_req_reg, lsu_we_reg, pc_req_reg, pc_seq_reg, wb_req_reg;
  logic             retire_reg, busy_reg, err_reg;
  logic [CNT_W-1:0] retire_cnt_reg;

  // Effective flags: live decoder outputs while in FLAGS, captured copy afterwards.
  logic   need_rf, need_alu, need_mem, need_we, need_pc, need_wb;
  state_t after_flags, after_rf, after_exec, after_mem, after_pc;
  logic   in_req, ack, timeout;

  // Routing to the next needed stage and handshake/timeout status.
  always_comb begin
    if (state_reg == S_FLAGS) begin
      need_rf  = bus.req_rf_ra_i | bus.req_rf_rb_i;
      need_alu = bus.req_alu_i;
      need_mem = bus.req_data_i;
      need_we  = bus.we_data_i;
      need_pc  = bus.req_pc_alu_i;
      need_wb  = bus.rd_we_i && (bus.rf_waddr_i != 5'd0);
    end else begin
      need_rf  = rf_flag_reg;
      need_alu = alu_flag_reg;
      need_mem = mem_flag_reg;
      need_we  = we_flag_reg;
      need_pc  = pc_flag_reg;
      need_wb  = wb_flag_reg;
    end
    after_pc    = need_wb  ? S_WB   : S_RETIRE;
    after_mem   = need_pc  ? S_PC   : after_pc;
    after_exec  = need_mem ? S_MEM  : after_mem;
    after_rf    = need_alu ? S_EXEC : after_exec;
    after_flags = need_rf  ? S_RF   : after_rf;

    in_req = 1'b0;
    ack    = 1'b0;
    case (state_reg)
      S_RF:    begin in_req = 1'b1; ack = bus.rf_ack_i;  end
      S_EXEC:  begin in_req = 1'b1; ack = bus.alu_ack_i; end
      S_MEM:   begin in_req = 1'b1; ack = bus.lsu_ack_i; end
      S_PC:    begin in_req = 1'b1; ack = bus.pc_ack_i;  end
      S_WB:    begin in_req = 1'b1; ack = bus.wb_ack_i;  end
      default: ;
    endcase
    // An ack in the same cycle as the last allowed wait cycle takes precedence.
    timeout = in_req && !ack && (wait_cnt_reg == TO_LAST);
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.instr_valid_i && instr_ready_reg) state_next = S_DECODE;
      S_DECODE: state_next = S_FLAGS;
      S_FLAGS:  state_next = after_flags;
      S_RF:     state_next = ack ? after_rf   : (timeout ? S_ERROR : S_RF);
      S_EXEC:   state_next = ack ? after_exec : (timeout ? S_ERROR : S_EXEC);
      S_MEM:    state_next = ack ? after_mem  : (timeout ? S_ERROR : S_MEM);
      S_PC:     state_next = ack ? after_pc   : (timeout ? S_ERROR : S_PC);
      S_WB:     state_next = ack ? S_RETIRE   : (timeout ? S_ERROR : S_WB);
      S_RETIRE: state_next = S_IDLE;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_IDLE;
    endcase
  end

  // State, captured flags, wait counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= '0;
      rf_flag_reg     <= 1'b0;
      alu_flag_reg    <= 1'b0;
      mem_flag_reg    <= 1'b0;
      we_flag_reg     <= 1'b0;
      pc_flag_reg     <= 1'b0;
      wb_flag_reg     <= 1'b0;
      instr_ready_reg <= 1'b1;
      dec_req_reg     <= 1'b0;
      rf_req_reg      <= 1'b0;
      alu_req_reg     <= 1'b0;
      lsu_req_reg     <= 1'b0;
      lsu_we_reg      <= 1'b0;
      pc_req_reg      <= 1'b0;
      pc_seq_reg      <= 1'b0;
      wb_req_reg      <= 1'b0;
      retire_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      err_reg         <= 1'b0;
      retire_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FLAGS) begin
        rf_flag_reg  <= need_rf;
        alu_flag_reg <= need_alu;
        mem_flag_reg <= need_mem;
        we_flag_reg  <= need_we;
        pc_flag_reg  <= need_pc;
        wb_flag_reg  <= need_wb;
      end
      if (state_next != state_reg) wait_cnt_reg <= '0;
      else if (in_req)             wait_cnt_reg <= wait_cnt_reg + 16'd1;
      instr_ready_reg <= (state_next == S_IDLE);
      dec_req_reg     <= (state_next == S_DECODE);
      rf_req_reg      <= (state_next == S_RF);
      alu_req_reg     <= (state_next == S_EXEC);
      lsu_req_reg     <= (state_next == S_MEM);
      lsu_we_reg      <= (state_next == S_MEM) && need_we;
      pc_req_reg      <= (state_next == S_PC);
      wb_req_reg      <= (state_next == S_WB);
      retire_reg      <= (state_next == S_RETIRE);
      pc_seq_reg      <= (state_next == S_RETIRE) && !need_pc;
      busy_reg        <= (state_next != S_IDLE);
      if (state_next == S_ERROR)  err_reg <= 1'b1;
      if (state_next == S_RETIRE) retire_cnt_reg <= retire_cnt_reg + 1'b1;
    end
  end

  assign bus.instr_ready_o = instr_ready_reg;
  assign bus.dec_req_o     = dec_req_reg;
  assign bus.rf_req_o      = rf_req_reg;
  assign bus.alu_req_o     = alu_req_reg;
  assign bus.lsu_req_o     = lsu_req_reg;
  assign bus.lsu_we_o      = lsu_we_reg;
  assign bus.pc_req_o      = pc_req_reg;
  assign bus.pc_seq_o      = pc_seq_reg;
  assign bus.wb_req_o      = wb_req_reg;
  assign bus.retire_o      = retire_reg;
  assign bus.retire_cnt_o  = retire_cnt_reg;
  assign bus.busy_o        = busy_reg;
  assign bus.err_o         = err_reg;
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl (CNT_W=3, TIMEOUT=4). Expected handshake events
// are queued when an instruction is issued and checked by a monitor as they occur.
module tb_issue_ctrl;
  localparam int EV_RF = 1, EV_ALU = 2, EV_LSU = 3, EV_PC = 4, EV_WB = 5, EV_RET = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   exp_cnt = 0;
  int   dly[5] = '{0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  issue_ctrl_if #(.CNT_W(3)) bus ();

  issue_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_check(input int ev);
    int exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("scoreboard event", ev, exp);
  endtask

  // Ack responder: ack a pending request once it has been high dly[k]+1 cycles.
  initial begin
    int wcnt[5] = '{0, 0, 0, 0, 0};
    logic [4:0] req_v, ack_v;
    bus.rf_ack_i = 0; bus.alu_ack_i = 0; bus.lsu_ack_i = 0;
    bus.pc_ack_i = 0; bus.wb_ack_i = 0;
    forever begin
      @(negedge clk);
      req_v = {bus.wb_req_o, bus.pc_req_o, bus.lsu_req_o, bus.alu_req_o, bus.rf_req_o};
      for (int k = 0; k < 5; k++) begin
        if (req_v[k]) begin
          ack_v[k] = (wcnt[k] >= dly[k]);
          wcnt[k]++;
        end else begin
          ack_v[k] = 1'b0;
          wcnt[k]  = 0;
        end
      end
      bus.rf_ack_i  = ack_v[0];
      bus.alu_ack_i = ack_v[1];
      bus.lsu_ack_i = ack_v[2];
      bus.pc_ack_i  = ack_v[3];
      bus.wb_ack_i  = ack_v[4];
    end
  end

  // Monitor: request rising edges and retire pulses against the scoreboard.
  initial begin
    logic [4:0] prev_v, cur_v;
    prev_v = '0;
    forever begin
      @(negedge clk);
      cur_v = {bus.wb_req_o, bus.pc_req_o, bus.lsu_req_o, bus.alu_req_o, bus.rf_req_o};
      for (int k = 0; k < 5; k++)
        if (cur_v[k] && !prev_v[k])
          sb_check(k + 1 + ((k == 2 && bus.lsu_we_o) ? 10 : 0));
      if (bus.retire_o) begin
        sb_check(EV_RET + (bus.pc_seq_o ? 10 : 0));
        exp_cnt = (exp_cnt + 1) % 8;
        chk("retire_cnt", 32'(bus.retire_cnt_o), exp_cnt);
      end
      prev_v = cur_v;
    end
  end

  task automatic drive_flags(input logic [6:0] f, input logic [4:0] waddr);
    {bus.req_rf_ra_i, bus.req_rf_rb_i, bus.req_alu_i, bus.req_data_i,
     bus.we_data_i, bus.req_pc_alu_i, bus.rd_we_i} = f;
    bus.rf_waddr_i = waddr;
  endtask

  // Flags f = {ra, rb, alu, data, we, pc_alu, rd_we}; d* are ack delays per stage.
  task automatic issue(input string tag, input logic [6:0] f, input logic [4:0] waddr,
                       input int d0, input int d1, input int d2, input int d3, input int d4);
    int lat, cyc;
    bit done;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3; dly[4] = d4;
    lat = 3;
    if (f[6] | f[5])               begin exp_q.push_back(EV_RF);  lat += d0 + 1; end
    if (f[4])                      begin exp_q.push_back(EV_ALU); lat += d1 + 1; end
    if (f[3])                      begin exp_q.push_back(EV_LSU + (f[2] ? 10 : 0)); lat += d2 + 1; end
    if (f[1])                      begin exp_q.push_back(EV_PC);  lat += d3 + 1; end
    if (f[0] && waddr != 5'd0)     begin exp_q.push_back(EV_WB);  lat += d4 + 1; end
    exp_q.push_back(EV_RET + (f[1] ? 0 : 10));
    cyc = 0;
    while (!bus.instr_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
    chk({tag, " ready before accept"}, 32'(bus.instr_ready_o), 1);
    drive_flags(f, waddr);
    bus.instr_valid_i = 1'b1;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    cyc = 1;
    chk({tag, " dec_req pulse"}, 32'(bus.dec_req_o), 1);
    chk({tag, " ready low when busy"}, 32'(bus.instr_ready_o), 0);
    done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk({tag, " dec_req one cycle"}, 32'(bus.dec_req_o), 0);
      if (cyc == 3) drive_flags(~f, ~waddr);
      if (bus.retire_o) done = 1;
    end
    chk({tag, " retired"}, 32'(done), 1);
    chk({tag, " latency"}, cyc, lat);
    $display("tx %s: latency %0d retire_cnt %0d pc_seq %0d", tag, cyc, bus.retire_cnt_o, bus.pc_seq_o);
    @(negedge clk);
    chk({tag, " retire one cycle"}, 32'(bus.retire_o), 0);
    chk({tag, " events consumed"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.instr_valid_i = 1'b0;
    drive_flags('0, '0);
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(bus.instr_ready_o), 1);
    chk("reset busy", 32'(bus.busy_o), 0);
    chk("reset err", 32'(bus.err_o), 0);
    chk("reset cnt", 32'(bus.retire_cnt_o), 0);
    chk("reset reqs", 32'({bus.dec_req_o, bus.rf_req_o, bus.alu_req_o, bus.lsu_req_o,
                          bus.pc_req_o, bus.wb_req_o, bus.retire_o, bus.pc_seq_o}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    //                       ra rb alu data we pc rdwe
    issue("addi x5",   7'b1_0_1_0_0_0_1, 5'd5, 0, 0, 0, 0, 0);
    issue("store",     7'b1_1_1_1_1_0_0, 5'd0, 0, 0, 3, 0, 0);
    issue("branch",    7'b1_1_1_0_0_1_0, 5'd0, 0, 0, 0, 1, 0);
    issue("write x0",  7'b0_0_1_0_0_0_1, 5'd0, 0, 0, 0, 0, 0);
    issue("ack at limit", 7'b0_0_1_0_0_0_0, 5'd0, 0, 3, 0, 0, 0);
    chk("no error on late ack", 32'(bus.err_o), 0);
    issue("load",      7'b0_0_1_1_0_0_1, 5'd7, 0, 0, 1, 0, 2);
    issue("nop",       7'b0_0_0_0_0_0_0, 5'd0, 0, 0, 0, 0, 0);
    issue("nop wrap",  7'b0_0_0_0_0_0_0, 5'd0, 0, 0, 0, 0, 0);
    chk("counter wrapped", 32'(bus.retire_cnt_o), 0);

    // Withheld ALU ack: error after 4 pending cycles, sticky until reset.
    dly[1] = 1000;
    exp_q.push_back(EV_ALU);
    drive_flags(7'b0_0_1_0_0_0_0, 5'd0);
    bus.instr_valid_i = 1'b1;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    cyc = 1;
    while (!bus.err_o && cyc < 50) begin @(negedge clk); cyc++; end
    chk("timeout cycle", cyc, 7);
    $display("tx timeout: err_o at cycle %0d", cyc);
    chk("error alu_req dropped", 32'(bus.alu_req_o), 0);
    chk("error ready low", 32'(bus.instr_ready_o), 0);
    bus.instr_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    bus.instr_valid_i = 1'b0;
    chk("error sticky", 32'(bus.err_o), 1);
    chk("error ready stays low", 32'(bus.instr_ready_o), 0);
    chk("error busy", 32'(bus.busy_o), 1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("reset clears err", 32'(bus.err_o), 0);
    chk("reset restores ready", 32'(bus.instr_ready_o), 1);
    @(negedge clk);
    rst_n = 1'b1;
    dly[1] = 0;
    @(negedge clk);

    // Reset during MEM aborts the instruction with no retire.
    dly[2] = 1000;
    exp_q.push_back(EV_LSU + 10);
    drive_flags(7'b0_0_0_1_1_0_0, 5'd0);
    bus.instr_valid_i = 1'b1;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    cyc = 1;
    while (!bus.lsu_req_o && cyc < 20) begin @(negedge clk); cyc++; end
    chk("mem reached", 32'(bus.lsu_req_o), 1);
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("async lsu_req drop", 32'(bus.lsu_req_o), 0);
    chk("async lsu_we drop", 32'(bus.lsu_we_o), 0);
    chk("async busy drop", 32'(bus.busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dly[2] = 0;
    repeat (3) @(negedge clk);
    $display("tx reset in MEM: busy %0d cnt %0d", bus.busy_o, bus.retire_cnt_o);
    chk("idle after abort", 32'(bus.instr_ready_o), 1);
    chk("count after abort", 32'(bus.retire_cnt_o), 0);
    chk("abort events consumed", exp_q.size(), 0);
    issue("post-reset", 7'b1_0_1_0_0_0_1, 5'd3, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
